// File: rtl/mem_burst_rd_fsm_if.sv
// rtl/mem_burst_rd_fsm_if.sv - command and memory-port bundle for the burst read controller
interface mem_burst_rd_fsm_if #(
    parameter int ADDR_W = 8,
    parameter int BLEN_W = 4
);
    logic              go;
    logic [ADDR_W-1:0] start_addr;
    logic [BLEN_W-1:0] burst_len;
    logic              ws;
    logic              abort;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              ds;
    logic              err;
    logic              err_cause;
    logic [BLEN_W-1:0] beat;
    logic              busy;

    // Sequencer/memory side: drives requests and wait status, observes the controller
    modport master (
        output go, start_addr, burst_len, ws, abort,
        input  rd, addr, ds, err, err_cause, beat, busy
    );

    // Controller side
    modport slave (
        input  go, start_addr, burst_len, ws, abort,
        output rd, addr, ds, err, err_cause, beat, busy
    );
endinterface

// File: rtl/mem_burst_rd_fsm.sv
// rtl/mem_burst_rd_fsm.sv - burst read controller with per-beat retry limit and abort
module mem_burst_rd_fsm #(
    parameter int ADDR_W    = 8,
    parameter int BLEN_W    = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_burst_rd_fsm_if.slave bus
);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    // One bit per strobe so rd/ds/err are plain state bits; DLY gets its own bit
    typedef enum logic [3:0] {
        IDLE = 4'b0000,
        READ = 4'b0001,
        DONE = 4'b0010,
        ERR  = 4'b0100,
        DLY  = 4'b1000
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [BLEN_W-1:0] beat_q;
    logic [BLEN_W-1:0] len_q;
    logic [3:0]        retry_q;
    logic              cause_q;

    // Burst sequencing: latch the request, walk beats, retry on ws, stop on abort/limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            retry_q <= '0;
            cause_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        state   <= READ;
                        addr_q  <= bus.start_addr;
                        len_q   <= bus.burst_len;
                        beat_q  <= '0;
                        retry_q <= '0;
                        cause_q <= 1'b0;
                    end
                end
                READ: begin
                    if (bus.abort) begin
                        state   <= ERR;
                        cause_q <= 1'b1;
                    end else begin
                        state <= DLY;
                    end
                end
                DLY: begin
                    if (bus.abort) begin
                        state   <= ERR;
                        cause_q <= 1'b1;
                    end else if (bus.ws) begin
                        if (retry_q < RETRY_MAX) begin
                            state   <= READ;
                            retry_q <= retry_q + 4'd1;
                        end else begin
                            state   <= ERR;
                            cause_q <= 1'b0;
                        end
                    end else if (beat_q == len_q) begin
                        state <= DONE;
                    end else begin
                        state   <= READ;
                        addr_q  <= addr_q + 1'b1;
                        beat_q  <= beat_q + 1'b1;
                        retry_q <= '0;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd        = state[0];
    assign bus.ds        = state[1];
    assign bus.err       = state[2];
    assign bus.busy      = |state;
    assign bus.addr      = addr_q;
    assign bus.beat      = beat_q;
    assign bus.err_cause = cause_q;
endmodule

// File: tb/tb_mem_burst_rd_fsm.sv
// tb/tb_mem_burst_rd_fsm.sv - scoreboard bench for the burst read controller
module tb_mem_burst_rd_fsm;
    localparam int AW = 8;
    localparam int BW = 4;
    localparam logic [3:0] K_NONE = 4'd0;
    localparam logic [3:0] K_RD   = 4'd1;
    localparam logic [3:0] K_DS   = 4'd2;
    localparam logic [3:0] K_ERR  = 4'd3;

    typedef struct {
        logic [3:0]    kind;
        logic [AW-1:0] addr;
        logic [BW-1:0] beat;
        logic          cause;
    } ev_t;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;
    int   abort_beat = -1;
    ev_t  sb[$];
    bit   ws_plan[$];

    mem_burst_rd_fsm_if #(.ADDR_W(AW), .BLEN_W(BW)) bus ();

    mem_burst_rd_fsm #(.ADDR_W(AW), .BLEN_W(BW), .MAX_RETRY(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] k, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic c);
        ev_t e;
        e.kind = k; e.addr = a; e.beat = b; e.cause = c;
        sb.push_back(e);
    endtask

    task automatic expect_ev(input string nm, input logic [3:0] k, input logic [AW-1:0] a,
                             input logic [BW-1:0] b, input logic c);
        ev_t e;
        if (sb.size() == 0) begin
            e.kind = K_NONE; e.addr = '0; e.beat = '0; e.cause = 1'b0;
        end else begin
            e = sb.pop_front();
        end
        check(nm, {15'd0, k, a, b, c}, {15'd0, e.kind, e.addr, e.beat, e.cause});
    endtask

    // Monitor: every strobe the DUT presents must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd)  expect_ev("rd_event",  K_RD,  bus.addr, bus.beat, 1'b0);
            if (bus.ds)  expect_ev("ds_event",  K_DS,  '0, '0, 1'b0);
            if (bus.err) expect_ev("err_event", K_ERR, '0, '0, bus.err_cause);
        end
    end

    // Memory responder: chooses ws for the coming DLY cycle and raises abort on a chosen beat
    always @(negedge clk) begin
        if (bus.rd) begin
            if (ws_plan.size() > 0) bus.ws = ws_plan.pop_front();
            else bus.ws = 1'b0;
            bus.abort = (abort_beat >= 0) && (int'(bus.beat) == abort_beat);
        end else begin
            bus.abort = 1'b0;
        end
    end

    task automatic run_burst(input logic [AW-1:0] a, input logic [BW-1:0] l, input int exp_end,
                             input int go_mid, input bit go_done);
        int i;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        bus.go = 1'b1; bus.start_addr = a; bus.burst_len = l;
        i = 0; seen = 0; busy_ok = 1;
        while (!seen && i < 200) begin
            @(negedge clk);
            i++;
            if (i == 1) begin
                bus.go = 1'b0;
                check("cause_cleared_on_go", {31'd0, bus.err_cause}, 32'd0);
            end
            if (i == go_mid) begin
                bus.go = 1'b1; bus.start_addr = 8'hAA; bus.burst_len = 4'hF;
            end else if (i == go_mid + 1) begin
                bus.go = 1'b0;
            end
            if (!bus.busy) busy_ok = 0;
            if (bus.ds || bus.err) seen = 1;
        end
        check("end_latency", i, exp_end);
        check("busy_during_burst", {31'd0, busy_ok}, 32'd1);
        if (go_done) begin
            bus.go = 1'b1; bus.start_addr = 8'hBB; bus.burst_len = 4'h2;
        end
    endtask

    task automatic check_idle(input int n, input logic exp_cause);
        repeat (n) begin
            @(negedge clk);
            check("idle_hold", {30'd0, bus.busy, bus.err_cause}, {30'd0, 1'b0, exp_cause});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.go = 1'b0; bus.start_addr = '0; bus.burst_len = '0;
        bus.ws = 1'b0; bus.abort = 1'b0;
        #1;
        check("reset_outputs",
              {13'd0, bus.rd, bus.ds, bus.err, bus.busy, bus.err_cause, bus.addr, bus.beat}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single beat
        push(K_RD, 8'h10, 4'd0, 1'b0); push(K_DS, '0, '0, 1'b0);
        run_burst(8'h10, 4'd0, 3, 0, 0);
        check_idle(2, 1'b0);

        // address wrap
        push(K_RD, 8'hFE, 4'd0, 1'b0); push(K_RD, 8'hFF, 4'd1, 1'b0);
        push(K_RD, 8'h00, 4'd2, 1'b0); push(K_RD, 8'h01, 4'd3, 1'b0);
        push(K_DS, '0, '0, 1'b0);
        run_burst(8'hFE, 4'd3, 9, 0, 0);

        // two retries on beat 0, then success
        ws_plan = '{1'b1, 1'b1};
        push(K_RD, 8'h40, 4'd0, 1'b0); push(K_RD, 8'h40, 4'd0, 1'b0); push(K_RD, 8'h40, 4'd0, 1'b0);
        push(K_RD, 8'h41, 4'd1, 1'b0); push(K_DS, '0, '0, 1'b0);
        run_burst(8'h40, 4'd1, 9, 0, 0);

        // retry limit exceeded
        ws_plan = '{1'b1, 1'b1, 1'b1, 1'b1};
        repeat (4) push(K_RD, 8'h50, 4'd0, 1'b0);
        push(K_ERR, '0, '0, 1'b0);
        run_burst(8'h50, 4'd2, 9, 0, 0);
        check_idle(2, 1'b0);

        // three retries on each of two beats: retry count must clear per beat
        ws_plan = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        repeat (4) push(K_RD, 8'h60, 4'd0, 1'b0);
        repeat (4) push(K_RD, 8'h61, 4'd1, 1'b0);
        push(K_DS, '0, '0, 1'b0);
        run_burst(8'h60, 4'd1, 17, 0, 0);

        // abort during beat 2 READ
        abort_beat = 2;
        push(K_RD, 8'h20, 4'd0, 1'b0); push(K_RD, 8'h21, 4'd1, 1'b0); push(K_RD, 8'h22, 4'd2, 1'b0);
        push(K_ERR, '0, '0, 1'b1);
        run_burst(8'h20, 4'd7, 6, 0, 0);
        abort_beat = -1;
        check_idle(3, 1'b1);

        // maximum length burst
        for (int k = 0; k < 16; k++) push(K_RD, 8'(8'hF8 + k), 4'(k), 1'b0);
        push(K_DS, '0, '0, 1'b0);
        run_burst(8'hF8, 4'hF, 33, 0, 0);

        // go while busy and in DONE is ignored; go in the first IDLE cycle starts a burst
        push(K_RD, 8'h30, 4'd0, 1'b0); push(K_RD, 8'h31, 4'd1, 1'b0); push(K_DS, '0, '0, 1'b0);
        push(K_RD, 8'h34, 4'd0, 1'b0); push(K_DS, '0, '0, 1'b0);
        run_burst(8'h30, 4'd1, 5, 2, 1);
        run_burst(8'h34, 4'd0, 3, 0, 0);
        check_idle(2, 1'b0);

        // asynchronous reset in the middle of DLY
        push(K_RD, 8'h70, 4'd0, 1'b0);
        @(negedge clk);
        bus.go = 1'b1; bus.start_addr = 8'h70; bus.burst_len = 4'd3;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {13'd0, bus.rd, bus.ds, bus.err, bus.busy, bus.err_cause, bus.addr, bus.beat}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(3, 1'b0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
